// File: rtl/sm_debug_ctrl_pkg.sv
// sm_debug_ctrl_pkg: host command opcodes and sequencer states shared by the debug controller
package sm_debug_ctrl_pkg;
  typedef enum logic [1:0] {OP_HALT = 2'b00, OP_RUN = 2'b01, OP_STEP = 2'b10, OP_READREG = 2'b11} dbgOp_t;
  typedef enum logic [2:0] {S_HALT, S_RUN, S_STEP, S_RDA, S_RDB} dbgState_t;
endpackage

// File: rtl/sm_debug_ctrl_stepcnt.sv
// sm_debug_ctrl_stepcnt: loadable down-counter of instructions left in a STEP, flags the last one
module sm_debug_ctrl_stepcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         isOne
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= loadVal;
    else if (dec) cnt <= cnt - W'(1);
  end
  assign isOne = cnt == W'(1);
endmodule

// File: rtl/sm_debug_ctrl.sv
// sm_debug_ctrl: run-control sequencer gating the sm_cpu clock enable and reading back core registers
module sm_debug_ctrl
  import sm_debug_ctrl_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              bp_en,
  input  logic [31:0]       bp_pc,
  output logic              cpu_en,
  output logic [4:0]        cpu_regAddr,
  input  logic [31:0]       cpu_regData,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              halted,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycle_cnt
);
  dbgState_t state;
  logic first, bpStop, haltReq, stepLoad, cntOne;
  logic [STEP_W-1:0] stepInit;
  // first masks the breakpoint for one cycle so a run started on the bp PC steps over it
  assign bpStop   = bp_en && cpu_regData == bp_pc && !first;
  assign cmd_ready = state == S_HALT || state == S_RUN;
  assign haltReq  = state == S_RUN && cmd_valid && cmd_op == OP_HALT;
  assign cpu_en   = (state == S_RUN || state == S_STEP) && !bpStop && !haltReq;
  assign stepLoad = state == S_HALT && cmd_valid && cmd_op == OP_STEP;
  assign stepInit = cmd_arg == '0 ? STEP_W'(1) : cmd_arg;
  sm_debug_ctrl_stepcnt #(.W(STEP_W)) u_stepcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (stepLoad),
    .dec     (state == S_STEP && cpu_en),
    .loadVal (stepInit),
    .isOne   (cntOne)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_HALT;
      first       <= 1'b0;
      cpu_regAddr <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      halted      <= 1'b1;
      bp_hit      <= 1'b0;
      cycle_cnt   <= '0;
    end else begin
      rd_valid  <= 1'b0;
      first     <= 1'b0;
      cycle_cnt <= cycle_cnt + CNT_W'(cpu_en);
      case (state)
        S_HALT: if (cmd_valid) begin
          case (dbgOp_t'(cmd_op))
            OP_RUN:     begin state <= S_RUN; first <= 1'b1; bp_hit <= 1'b0; halted <= 1'b0; end
            OP_STEP:    begin state <= S_STEP; first <= 1'b1; bp_hit <= 1'b0; halted <= 1'b0; end
            OP_READREG: begin state <= S_RDA; cpu_regAddr <= cmd_arg[4:0]; halted <= 1'b0; end
            default:    ;
          endcase
        end
        S_RUN: if (bpStop || haltReq) begin
          state  <= S_HALT;
          halted <= 1'b1;
          bp_hit <= bp_hit | bpStop;
        end
        S_STEP: if (bpStop || cntOne) begin
          state  <= S_HALT;
          halted <= 1'b1;
          bp_hit <= bp_hit | bpStop;
        end
        S_RDA: state <= S_RDB;
        S_RDB: begin
          rd_data     <= cpu_regData;
          rd_valid    <= 1'b1;
          cpu_regAddr <= '0;
          state       <= S_HALT;
          halted      <= 1'b1;
        end
        default: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end
endmodule
